// File: rtl/operand_loader.sv
// operand_loader: synchronises the slide switches and the load button, debounces
// the button and captures one switch snapshot per accepted press into N. Each
// capture fires a restart pulse of RESTART_CYCLES cycles for the processor.
// Build option: define OPERAND_AUTOLOAD_EN to bypass the button. The switches
// are then debounced as a vector, and any stable value that differs from N is
// captured automatically.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RELEASE_CYCLES  = 500000,
    parameter int RESTART_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_load,
    output logic [7:0] N,
    output logic       n_valid,
    output logic       restart,
    output logic       busy
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RS_W    = $clog2(RESTART_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [RS_W-1:0]  RS_LOAD  = RS_W'(RESTART_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, HOLD} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [RS_W-1:0]  rs_cnt;
    logic             capture;
    logic [7:0]       sw_m, sw_s, cap_val;

    // The debounce counter saturates and never wraps.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign busy    = (state != IDLE);

`ifdef OPERAND_AUTOLOAD_EN
    logic [7:0] sw_last;

    // Two-flop switch synchroniser plus a one-cycle history used to spot changes.
    // NOTE: clocked state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m    <= '0;
            sw_s    <= '0;
            sw_last <= '0;
        end else begin
            sw_m    <= sw;
            sw_s    <= sw_m;
            sw_last <= sw_s;
        end
    end

    // Capture the value that was stable throughout the debounce window.
    assign cap_val = sw_last;

    // Next-state logic: debounce sw_s as a vector against the current operand.
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (sw_s != N) begin
                    state_nx = (DEBOUNCE_CYCLES <= 1) ? CAPTURE : ARM;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ARM: begin
                if (sw_s == N) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (sw_s != sw_last) begin
                    cnt_nx   = CNT_W'(1);
                end else if (cnt >= DEB_LAST) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            CAPTURE: begin
                capture  = 1'b1;
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
`else
    logic       btn_m, btn_s;
    logic [1:0] sync_ok;
    logic       armed;

    // Two-flop synchronisers for the switches and the load button.
    // NOTE: clocked state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            btn_m <= btn_load;
            btn_s <= btn_m;
        end
    end

    // Arm only after a genuine low on btn_s, once the synchroniser has refilled
    // after reset. A button held through reset therefore cannot capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ok <= '0;
            armed   <= 1'b0;
        end else begin
            sync_ok <= {sync_ok[0], 1'b1};
            if (sync_ok[1] && !btn_s) armed <= 1'b1;
        end
    end

    assign cap_val = sw_s;

    // Next-state logic: press debounce, capture, then wait for a clean release.
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && btn_s) begin
                    state_nx = (DEBOUNCE_CYCLES <= 1) ? CAPTURE : ARM;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ARM: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt >= DEB_LAST) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            CAPTURE: begin
                capture  = 1'b1;
                state_nx = HOLD;
                cnt_nx   = '0;
            end
            HOLD: begin
                if (btn_s) begin
                    cnt_nx   = '0;
                end else if (cnt >= REL_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
`endif

    // State and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Operand capture and restart pulse. A capture during a pulse reloads the
    // counter, which stretches the pulse rather than producing a second one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            N       <= 8'h00;
            n_valid <= 1'b0;
            rs_cnt  <= '0;
            restart <= 1'b0;
        end else if (capture) begin
            N       <= cap_val;
            n_valid <= 1'b1;
            rs_cnt  <= RS_LOAD;
            restart <= 1'b1;
        end else if (rs_cnt != '0) begin
            rs_cnt  <= rs_cnt - 1'b1;
            restart <= (rs_cnt != RS_W'(1));
        end else begin
            restart <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader (DEBOUNCE=4, RELEASE=4, RESTART=2).
// The button-mode tests run by default. The autoload tests run when
// OPERAND_AUTOLOAD_EN is defined.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       btn_load;
    logic [7:0] N;
    logic       n_valid;
    logic       restart;
    logic       busy;

    int errors = 0;
    int checks = 0;

    operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .RELEASE_CYCLES (4),
        .RESTART_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn_load(btn_load),
        .N       (N),
        .n_valid (n_valid),
        .restart (restart),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic       btn;
        logic [7:0] exp_n;
        logic       exp_valid;
        logic       exp_restart;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic [7:0] s, input logic b, input logic [7:0] n,
                           input logic v, input logic r, input logic bz);
        vec_t row;
        row.sw = s; row.btn = b; row.exp_n = n;
        row.exp_valid = v; row.exp_restart = r; row.exp_busy = bz;
        vecs.push_back(row);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to budget cycles for restart to be seen high.
    task automatic wait_restart(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (restart) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Count restart rising edges over n cycles.
    task automatic count_rises(input int n, output int rises);
        logic prev;
        prev  = restart;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (restart && !prev) rises++;
            prev = restart;
        end
    endtask

    initial begin
        bit found;
        int rises;
        int odd;

        rst = 1'b1; sw = 8'h00; btn_load = 1'b0;
        repeat (3) tick();
        check("reset N", 32'(N), 32'h00);
        check("reset n_valid", 32'(n_valid), 32'h0);
        check("reset restart", 32'(restart), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        odd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (N != 8'h00 || n_valid || restart || busy) odd++;
        end
        check("idle after reset (non-idle cycles)", 32'(odd), 32'h0);

`ifdef OPERAND_AUTOLOAD_EN
        sw = 8'h3C;
        wait_restart(20, found);
        check("autoload capture seen", 32'(found), 32'h1);
        check("autoload N", 32'(N), 32'h3C);
        check("autoload n_valid", 32'(n_valid), 32'h1);
        tick();
        check("autoload restart 2nd cycle", 32'(restart), 32'h1);
        tick();
        check("autoload restart ends", 32'(restart), 32'h0);
        count_rises(10, rises);
        check("autoload single pulse", 32'(rises), 32'h0);

        sw = 8'h3D;
        tick(); tick();
        sw = 8'h3C;
        count_rises(12, rises);
        check("glitch no capture", 32'(rises), 32'h0);
        check("glitch N unchanged", 32'(N), 32'h3C);
        check("glitch busy idle", 32'(busy), 32'h0);

        sw = 8'h5A;
        wait_restart(20, found);
        check("autoload second value seen", 32'(found), 32'h1);
        check("autoload second N", 32'(N), 32'h5A);
`else
        // Clean press: button high for 10 cycles, then released.
        for (int r = 0; r < 20; r++) begin
            logic       b;
            logic [7:0] n;
            b = (r < 10);
            n = (r >= 6) ? 8'hF0 : 8'h00;
            add_row(8'hF0, b, n, (r >= 6), (r == 6 || r == 7), (r >= 2 && r <= 14));
        end
        // Bounce: 1,1,0,1,1,1,0 then low. Switches move but N must not.
        add_row(8'hAA, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        add_row(8'hAA, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        add_row(8'hAA, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1);
        add_row(8'hAA, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
        add_row(8'hAA, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        add_row(8'hAA, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
        add_row(8'hAA, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1);
        add_row(8'hAA, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1);
        add_row(8'hAA, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
        add_row(8'hAA, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            sw       = vecs[i].sw;
            btn_load = vecs[i].btn;
            tick();
            check($sformatf("row%0d N", i), 32'(N), 32'(vecs[i].exp_n));
            check($sformatf("row%0d n_valid", i), 32'(n_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d restart", i), 32'(restart), 32'(vecs[i].exp_restart));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Re-arm: a short release during HOLD must not allow a second capture.
        sw = 8'h55; btn_load = 1'b1;
        wait_restart(20, found);
        check("rearm first capture seen", 32'(found), 32'h1);
        check("rearm first N", 32'(N), 32'h55);
        tick(); tick();
        btn_load = 1'b0;
        tick(); tick();
        sw = 8'h0F; btn_load = 1'b1;
        count_rises(10, rises);
        check("rearm short release no capture", 32'(rises), 32'h0);
        check("rearm N held", 32'(N), 32'h55);
        btn_load = 1'b0;
        repeat (8) tick();
        check("rearm back to idle", 32'(busy), 32'h0);
        btn_load = 1'b1;
        wait_restart(20, found);
        check("rearm second capture seen", 32'(found), 32'h1);
        check("rearm second N", 32'(N), 32'h0F);
        btn_load = 1'b0;
        repeat (10) tick();

        // Reset during ARM with the button held through reset.
        sw = 8'h77; btn_load = 1'b1;
        repeat (3) tick();
        check("in ARM before reset", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst in ARM busy", 32'(busy), 32'h0);
        check("rst in ARM N", 32'(N), 32'h00);
        check("rst in ARM n_valid", 32'(n_valid), 32'h0);
        tick();
        rst = 1'b0;
        odd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy || restart) odd++;
        end
        check("held through reset no capture", 32'(odd), 32'h0);

        // Reset during the restart pulse drops it without waiting for a clock.
        btn_load = 1'b0;
        repeat (5) tick();
        sw = 8'h99; btn_load = 1'b1;
        wait_restart(20, found);
        check("pre-reset capture seen", 32'(found), 32'h1);
        check("pre-reset N", 32'(N), 32'h99);
        #2 rst = 1'b1;
        #1;
        check("rst in pulse restart", 32'(restart), 32'h0);
        check("rst in pulse N", 32'(N), 32'h00);
        check("rst in pulse busy", 32'(busy), 32'h0);
        check("rst in pulse n_valid", 32'(n_valid), 32'h0);
        btn_load = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("post-reset N stays zero", 32'(N), 32'h00);
        check("post-reset restart low", 32'(restart), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
